// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
// Segment codes are ordered a..g, active-high.
package pwm_pkg;

  localparam logic [0:6] SEG_0     = 7'b1111110;
  localparam logic [0:6] SEG_1     = 7'b0110000;
  localparam logic [0:6] SEG_2     = 7'b1101101;
  localparam logic [0:6] SEG_3     = 7'b1111001;
  localparam logic [0:6] SEG_4     = 7'b0110011;
  localparam logic [0:6] SEG_5     = 7'b1011011;
  localparam logic [0:6] SEG_6     = 7'b1011111;
  localparam logic [0:6] SEG_7     = 7'b1110000;
  localparam logic [0:6] SEG_8     = 7'b1111111;
  localparam logic [0:6] SEG_9     = 7'b1111011;
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hf;

  function automatic logic [11:0] to_bcd(
    input logic [15:0] v
  );
    return {4'((v / 16'd100) % 16'd10),
            4'((v / 16'd10) % 16'd10),
            4'(v % 16'd10)};
  endfunction

endpackage

// File: rtl/pwm_multi_gen_if.sv
// Button/selection inputs and PWM/display outputs of the
// multi-channel PWM generator.
interface pwm_multi_gen_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);

  logic             inc_n;
  logic             inc10_n;
  logic             dec_n;
  logic             dec10_n;
  logic [2:0]       sel;
  logic             center;
  logic [CH-1:0]    pwm;
  logic [CNT_W-1:0] duty;
  logic [0:6]       seg0;
  logic [0:6]       seg1;
  logic [0:6]       seg2;
  logic [0:6]       seg3;

  modport master (
    output inc_n, inc10_n, dec_n, dec10_n,
    output sel, center,
    input  pwm, duty,
    input  seg0, seg1, seg2, seg3
  );

  modport slave (
    input  inc_n, inc10_n, dec_n, dec10_n,
    input  sel, center,
    output pwm, duty,
    output seg0, seg1, seg2, seg3
  );

endinterface

// File: rtl/seg7_dec.sv
// BCD digit to active-high 7-segment code (a..g).
// Codes above 9 blank the digit.
module seg7_dec
  import pwm_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM with button-set duty, period-aligned
// shadow registers and 7-segment readout of the selected channel.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CH       = 4,
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 100,
  parameter int FINE     = 1,
  parameter int COARSE   = 10,
  parameter int RST_DUTY = 0
) (
  input  logic           clkin,
  input  logic           reset,
  pwm_multi_gen_if.slave io
);

  localparam int DW = CNT_W + 2;

  localparam logic [CNT_W-1:0] P    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] PM1  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] RD   = CNT_W'(RST_DUTY);
  localparam logic [CNT_W-1:0] ROFF =
    CNT_W'((PERIOD - RST_DUTY) / 2);

  localparam logic signed [DW-1:0] DF = DW'(FINE);
  localparam logic signed [DW-1:0] DC = DW'(COARSE);
  localparam logic signed [DW-1:0] DP = DW'(PERIOD);

  if (CH < 1 || CH > 8 ||
      PERIOD < 2 || PERIOD > 999 ||
      PERIOD > (1 << CNT_W) - 1 ||
      RST_DUTY < 0 || RST_DUTY > PERIOD) begin : g_bad
    $error("pwm_multi_gen: illegal parameters");
  end

  logic [3:0] s1, s2, s3;
  logic [3:0] press;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= {io.dec10_n, io.dec_n,
             io.inc10_n, io.inc_n};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s3 & ~s2;

  logic [CNT_W-1:0] cnt;
  logic             sh_mode;
  logic             wrap;

  assign wrap = (cnt == PM1);

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      sh_mode <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) sh_mode <= io.center;
    end
  end

  logic [CNT_W-1:0]     duty_a [CH];
  logic [CNT_W-1:0]     cur;
  logic [CNT_W-1:0]     nxt;
  logic                 valid;
  logic signed [DW-1:0] delta;
  logic signed [DW-1:0] sum;

  always_comb begin
    valid = {1'b0, io.sel} < 4'(CH);
    cur   = '0;
    for (int i = 0; i < CH; i++)
      if (io.sel == 3'(i)) cur = duty_a[i];
    delta = (press[0] ? DF : '0)
          + (press[1] ? DC : '0)
          - (press[2] ? DF : '0)
          - (press[3] ? DC : '0);
    sum = $signed({2'b00, cur}) + delta;
    nxt = sum[CNT_W-1:0];
    if (sum < 0)       nxt = '0;
    else if (sum > DP) nxt = P;
  end

  logic [CH-1:0] pwm_v;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] d, sd, so;
    logic [CNT_W-1:0] lo, hi;
    logic             p;

    // Window [lo, hi) over the shared counter; lo is 0 in edge mode.
    assign lo = sh_mode ? so : '0;
    assign hi = lo + sd;

    always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
        d  <= RD;
        sd <= RD;
        so <= ROFF;
        p  <= 1'b0;
      end else begin
        if (|press && io.sel == 3'(i)) d <= nxt;
        if (wrap) begin
          sd <= d;
          so <= (P - d) >> 1;
        end
        p <= (cnt >= lo) && (cnt < hi);
      end
    end

    assign duty_a[i] = d;
    assign pwm_v[i]  = p;
  end

  logic [11:0] bcd;
  logic [3:0]  d0, d1, d2, d3;

  assign bcd = to_bcd(16'(cur));
  assign d0  = valid ? bcd[3:0]       : BCD_BLANK;
  assign d1  = valid ? bcd[7:4]       : BCD_BLANK;
  assign d2  = valid ? bcd[11:8]      : BCD_BLANK;
  assign d3  = valid ? {1'b0, io.sel} : BCD_BLANK;

  assign io.pwm  = pwm_v;
  assign io.duty = valid ? cur : '0;

  seg7_dec u_seg0 (.bcd(d0), .seg(io.seg0));
  seg7_dec u_seg1 (.bcd(d1), .seg(io.seg1));
  seg7_dec u_seg2 (.bcd(d2), .seg(io.seg2));
  seg7_dec u_seg3 (.bcd(d3), .seg(io.seg3));

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: buttons, saturation,
// shadowing, edge/center windows, display and async reset.
module tb_pwm_multi_gen;

  localparam int P = 100;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S3 = 7'b1111001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pwm_multi_gen_if #(.CH(4), .CNT_W(8)) bus ();

  pwm_multi_gen #(
    .CH(4), .CNT_W(8), .PERIOD(P),
    .FINE(1), .COARSE(10), .RST_DUTY(0)
  ) dut (
    .clkin(clk),
    .reset(rst_n),
    .io(bus)
  );

  int checks = 0;
  int fails  = 0;
  int tcnt;

  // Reference period counter, reset alongside the DUT.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= 0;
    else        tcnt <= (tcnt == P - 1) ? 0 : tcnt + 1;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic btn(input int b, input logic v);
    case (b)
      0: bus.inc_n   = v;
      1: bus.inc10_n = v;
      2: bus.dec_n   = v;
      3: bus.dec10_n = v;
      default: ;
    endcase
  endtask

  task automatic press(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) btn(b, 1'b0);
      repeat (3) @(negedge clk);
      btn(b, 1'b1);
      repeat (2) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cnt(input int c);
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 250 && !hit; k++) begin
      if (tcnt == c) hit = 1'b1;
      else @(negedge clk);
    end
    chk("wait_cnt", 128'(hit), 128'(1));
  endtask

  function automatic logic [99:0] win(input int lo,
                                      input int hi);
    logic [99:0] v;
    for (int i = 0; i < 100; i++)
      v[i] = (i >= lo) && (i < hi);
    return v;
  endfunction

  // v[i] is the output decided at counter value i
  // (visible one cycle later); mid=1 presses dec10 3x from cnt 30.
  task automatic sample(input int ch, input bit mid,
                        output logic [99:0] v);
    wait_cnt(1);
    for (int i = 0; i < 100; i++) begin
      v[i] = bus.pwm[ch];
      if (mid && (i == 30 || i == 36 || i == 42))
        btn(3, 1'b0);
      if (mid && (i == 33 || i == 39 || i == 45))
        btn(3, 1'b1);
      @(negedge clk);
    end
  endtask

  logic [99:0] v;

  initial begin
    bus.inc_n   = 1'b1;
    bus.inc10_n = 1'b1;
    bus.dec_n   = 1'b1;
    bus.dec10_n = 1'b1;
    bus.sel     = 3'd0;
    bus.center  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pwm",  128'(bus.pwm),  128'(0));
    chk("rst_duty", 128'(bus.duty), 128'(0));
    chk("rst_seg0", 128'(bus.seg0), 128'(S0));
    chk("rst_seg1", 128'(bus.seg1), 128'(S0));
    chk("rst_seg2", 128'(bus.seg2), 128'(S0));
    chk("rst_seg3", 128'(bus.seg3), 128'(S0));

    press(0, 10);
    chk("duty10", 128'(bus.duty), 128'(10));
    chk("d10_seg0", 128'(bus.seg0), 128'(S0));
    chk("d10_seg1", 128'(bus.seg1), 128'(S1));
    sample(0, 1'b0, v);
    chk("edge10", 128'(v), 128'(win(0, 10)));

    press(1, 12);
    chk("sat_hi", 128'(bus.duty), 128'(100));
    chk("sat_seg2", 128'(bus.seg2), 128'(S1));
    sample(0, 1'b0, v);
    chk("edge100", 128'(v), 128'(win(0, 100)));
    press(3, 3);
    chk("duty70", 128'(bus.duty), 128'(70));
    press(2, 105);
    chk("sat_lo", 128'(bus.duty), 128'(0));
    sample(0, 1'b0, v);
    chk("edge0", 128'(v), 128'(win(0, 0)));

    bus.sel = 3'd1;
    press(1, 5);
    chk("duty50", 128'(bus.duty), 128'(50));
    sample(1, 1'b1, v);
    chk("keep50", 128'(v), 128'(win(0, 50)));
    chk("duty20", 128'(bus.duty), 128'(20));
    sample(1, 1'b0, v);
    chk("next20", 128'(v), 128'(win(0, 20)));

    bus.center = 1'b1;
    bus.sel    = 3'd2;
    press(1, 4);
    sample(2, 1'b0, v);
    chk("ctr40", 128'(v), 128'(win(30, 70)));
    press(0, 1);
    chk("duty41", 128'(bus.duty), 128'(41));
    sample(2, 1'b0, v);
    chk("ctr41", 128'(v), 128'(win(29, 70)));
    bus.sel = 3'd3;
    press(1, 10);
    sample(3, 1'b0, v);
    chk("ctr100", 128'(v), 128'(win(0, 100)));

    bus.center = 1'b0;
    bus.sel    = 3'd0;
    @(negedge clk);
    bus.inc10_n = 1'b0;
    bus.dec_n   = 1'b0;
    repeat (3) @(negedge clk);
    bus.inc10_n = 1'b1;
    bus.dec_n   = 1'b1;
    repeat (4) @(negedge clk);
    chk("sum_p9", 128'(bus.duty), 128'(9));

    bus.sel = 3'd5;
    @(negedge clk);
    chk("blank", 128'({bus.seg3, bus.seg2,
                       bus.seg1, bus.seg0}), 128'(0));
    press(0, 2);
    bus.sel = 3'd0;
    @(negedge clk);
    chk("sel5_ch0", 128'(bus.duty), 128'(9));
    bus.sel = 3'd1;
    @(negedge clk);
    chk("sel5_ch1", 128'(bus.duty), 128'(20));
    bus.sel = 3'd2;
    @(negedge clk);
    chk("sel5_ch2", 128'(bus.duty), 128'(41));
    bus.sel = 3'd3;
    @(negedge clk);
    chk("sel5_ch3", 128'(bus.duty), 128'(100));
    chk("seg3_3", 128'(bus.seg3), 128'(S3));

    bus.sel = 3'd0;
    @(negedge clk) bus.inc_n = 1'b0;
    @(negedge clk) bus.inc_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("glitch",
        128'((bus.duty == 8'd9) || (bus.duty == 8'd10)),
        128'(1));

    bus.sel = 3'd3;
    wait_cnt(40);
    chk("pre_rst", 128'(bus.pwm[3]), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("async_pwm",  128'(bus.pwm),  128'(0));
    chk("async_duty", 128'(bus.duty), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    sample(3, 1'b0, v);
    chk("post_rst", 128'(v), 128'(win(0, 0)));
    bus.sel = 3'd1;
    @(negedge clk);
    chk("post_ch1", 128'(bus.duty), 128'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
